// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one-entry result buffer per execution lane, round-robin
// selection of one buffered result per cycle onto a registered broadcast bus.
module cdb_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int PR_WIDTH   = 6,
  parameter int ROB_WIDTH  = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*PR_WIDTH-1:0]     req_pdest,
  input  logic [NUM_REQ*ROB_WIDTH-1:0]    req_rob_idx,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic                            cdb_valid,
  output logic [PR_WIDTH-1:0]             cdb_pdest,
  output logic [ROB_WIDTH-1:0]            cdb_rob_idx,
  output logic [DATA_WIDTH-1:0]           cdb_data,
  output logic                            cdb_regf_we,
  output logic [1:0]                      cdb_src
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    held;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    accept;
  logic [PR_WIDTH-1:0]   pdest_q [NUM_REQ];
  logic [ROB_WIDTH-1:0]  rob_q   [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_q  [NUM_REQ];
  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      rr_next;
  logic                  found;
  logic [PR_WIDTH-1:0]   sel_pdest;
  logic [ROB_WIDTH-1:0]  sel_rob;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [1:0]            sel_src;

  // k is the distance from rr_ptr; lane i sits at distance k when rr_ptr+k wraps onto i.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && held[i] &&
            ((int'(rr_ptr) + k == i) || (int'(rr_ptr) + k == i + NUM_REQ))) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_pdest = '0;
    sel_rob   = '0;
    sel_data  = '0;
    sel_src   = '0;
    rr_next   = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_pdest = pdest_q[i];
        sel_rob   = rob_q[i];
        sel_data  = data_q[i];
        sel_src   = 2'(i);
        rr_next   = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  assign req_ready = flush ? '0 : (~held | grant);
  assign accept    = req_valid & req_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held        <= '0;
      rr_ptr      <= '0;
      cdb_valid   <= 1'b0;
      cdb_regf_we <= 1'b0;
      cdb_pdest   <= '0;
      cdb_rob_idx <= '0;
      cdb_data    <= '0;
      cdb_src     <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        pdest_q[i] <= '0;
        rob_q[i]   <= '0;
        data_q[i]  <= '0;
      end
    end else if (flush) begin
      held        <= '0;
      cdb_valid   <= 1'b0;
      cdb_regf_we <= 1'b0;
    end else begin
      // A granted lane may refill on the same edge it drains.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) begin
          held[i]    <= 1'b1;
          pdest_q[i] <= req_pdest[i*PR_WIDTH +: PR_WIDTH];
          rob_q[i]   <= req_rob_idx[i*ROB_WIDTH +: ROB_WIDTH];
          data_q[i]  <= req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end else if (grant[i]) begin
          held[i] <= 1'b0;
        end
      end
      if (found) begin
        cdb_valid   <= 1'b1;
        cdb_regf_we <= |sel_pdest;
        cdb_pdest   <= sel_pdest;
        cdb_rob_idx <= sel_rob;
        cdb_data    <= sel_data;
        cdb_src     <= sel_src;
        rr_ptr      <= rr_next;
      end else begin
        cdb_valid   <= 1'b0;
        cdb_regf_we <= 1'b0;
      end
    end
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between the execution units fed by rename/dispatch: add/branch ALU, multiplier, load/store.
- Each unit hands a completed result into a one-entry lane buffer. A round-robin arbiter moves one buffered result per cycle onto a registered CDB.
- The CDB broadcasts to the ROB, the reservation-station wakeup logic and the physical regfile.
- A flush on mispredict discards every in-flight result.

Parameters:
NUM_REQ, 3, number of requesting units (lane 0 = add, 1 = mul, 2 = ls)
PR_WIDTH, 6, physical register index width
ROB_WIDTH, 4, ROB index width
DATA_WIDTH, 32, result data width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset (asserted when 0)
flush  in  1  synchronous discard of all lane and CDB state
req_valid  in  NUM_REQ  per-lane result valid
req_ready  out  NUM_REQ  per-lane accept
req_pdest  in  NUM_REQ*PR_WIDTH  per-lane destination phys reg (lane i at [i*PR_WIDTH +: PR_WIDTH])
req_rob_idx  in  NUM_REQ*ROB_WIDTH  per-lane ROB index
req_data  in  NUM_REQ*DATA_WIDTH  per-lane result
cdb_valid  out  1  broadcast valid (registered)
cdb_pdest  out  PR_WIDTH  broadcast phys reg
cdb_rob_idx  out  ROB_WIDTH  broadcast ROB index
cdb_data  out  DATA_WIDTH  broadcast data
cdb_regf_we  out  1  regfile write enable = cdb_valid && cdb_pdest != 0 (registered)
cdb_src  out  2  lane that produced the current broadcast

Behaviour:
- Reset (rst=0, async): all lane held bits = 0, lane payloads = 0, rr_ptr = 0. cdb_valid, cdb_regf_we, cdb_pdest, cdb_rob_idx, cdb_data and cdb_src are all 0.
- Lane state per i: held[i] plus a payload (pdest, rob_idx, data).
- Grant logic:
  - grant is one-hot and is a function of held[] and rr_ptr only, never of req_valid.
  - Select the first held lane searching from rr_ptr upward, modulo NUM_REQ.
  - If no lane is held, grant = 0.
- req_ready[i] = !flush && (!held[i] || grant[i]). There is no combinational path from req_valid to req_ready.
- Lane update each edge:
  - Accept (req_valid[i] && req_ready[i]) loads the payload and sets held[i]=1. This includes the case where the same lane is granted in the same cycle, giving back-to-back throughput of 1 per cycle per lane.
  - Grant without accept clears held[i].
- CDB update each edge:
  - If any grant: cdb_valid=1, payload taken from the granted lane, cdb_src = lane index, cdb_regf_we = (pdest != 0).
  - Otherwise cdb_valid=0 and cdb_regf_we=0. Payload fields hold their last values.
- Round-robin pointer:
  - On a grant to lane g, rr_ptr <= (g+1) mod NUM_REQ.
  - With no grant, rr_ptr holds.
  - Width is ceil(log2(NUM_REQ)). Lanes are contiguous from 0 to NUM_REQ-1; the search never examines an index >= NUM_REQ.
- Latency: result accepted at edge T, on CDB after edge T+1 if uncontended. Worst case with all lanes held is NUM_REQ edges.
- Fairness: a held lane waits at most NUM_REQ-1 grants to other lanes.
- Flush:
  - At the next edge, all held bits clear, cdb_valid=0 and cdb_regf_we=0.
  - req_ready is 0 during the flush cycle, so inputs that cycle are dropped.
  - rr_ptr is unchanged.
  - flush overrides any simultaneous accept or grant.
- Async reset mid-operation: outputs clear immediately, independent of clk. Held results are lost.
- pdest = 0 results (stores, branches, rd=x0) still broadcast with cdb_valid=1 so the ROB marks completion. cdb_regf_we = 0 for these.
- The CDB consumer is never backpressured.

Test Plan:
- Reset: rst=0 mid-cycle with lanes held -> cdb_valid=0, req_ready=3'b111 immediately; after release with no requests, cdb_valid stays 0.
- Single lane: lane 1 valid for one cycle with pdest=5, rob_idx=3, data=0xDEADBEEF -> one edge later cdb_valid=1, cdb_pdest=5, cdb_rob_idx=3, cdb_data=0xDEADBEEF, cdb_src=1, cdb_regf_we=1.
- Contention: all three lanes valid every cycle from rr_ptr=0 -> cdb_src sequence 0,1,2,0,1,2; req_ready asserted only on the granted lane each cycle after the first.
- Back-to-back lane: lane 0 alone, valid 8 consecutive cycles with rob_idx 0..7 -> 8 consecutive cdb_valid cycles carrying rob_idx 0..7 in order, with no bubbles.
- x0 destination: lane 2 with pdest=0, rob_idx=9 -> cdb_valid=1, cdb_rob_idx=9, cdb_regf_we=0.
- Flush: lanes 0 and 2 held, flush=1 with lane 1 valid in the same cycle -> next edge cdb_valid=0 and no held lanes; lane 1 result is never broadcast; rr_ptr is unchanged.
